// File: rtl/status_flag_unit.sv
// rtl/status_flag_unit.sv - NZCV producer: CPSR/SPSR flag registers and condition bus (optional macro FLAG_FORWARD_EN)
module status_flag_unit #(
  parameter int          DATA_W   = 32,
  parameter logic [3:0]  RST_NZCV = 4'b0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] alu_res,
  input  logic              alu_c,
  input  logic              alu_v,
  input  logic              sh_c,
  input  logic              logic_op,
  input  logic              s_bit,
  input  logic              ex_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic              exc_entry,
  input  logic              exc_return,
  output logic [3:0]        nzcv,
  output logic [3:0]        spsr_nzcv,
  output logic              spsr_valid,
  output logic              ret_err
);

  logic [3:0] cpsr_q, cpsr_d;
  logic [3:0] spsr_q, spsr_d;
  logic       spsr_valid_q, spsr_valid_d;
  logic       ret_err_q, ret_err_d;

  logic       upd;
  logic [3:0] new_flags;
  logic [3:0] post_upd;

  assign upd = ex_valid & s_bit & ~stall & ~flush;

  // Flags produced by the EX instruction; logical ops keep the old V bit
  always_comb begin
    new_flags    = 4'b0000;
    new_flags[3] = alu_res[DATA_W-1];
    new_flags[2] = (alu_res == '0);
    new_flags[1] = logic_op ? sh_c : alu_c;
    new_flags[0] = logic_op ? cpsr_q[0] : alu_v;
  end

  assign post_upd = upd ? new_flags : cpsr_q;

  // Next-state: stall freezes everything; return beats entry beats plain update
  always_comb begin
    cpsr_d       = cpsr_q;
    spsr_d       = spsr_q;
    spsr_valid_d = spsr_valid_q;
    ret_err_d    = 1'b0;
    if (!stall) begin
      if (exc_return) begin
        if (spsr_valid_q) begin
          cpsr_d       = spsr_q;
          spsr_valid_d = 1'b0;
        end else begin
          ret_err_d = 1'b1;
        end
      end else begin
        cpsr_d = post_upd;
        if (exc_entry) begin
          spsr_d       = post_upd;
          spsr_valid_d = 1'b1;
        end
      end
    end
  end

  // Architectural flag state with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpsr_q       <= RST_NZCV;
      spsr_q       <= RST_NZCV;
      spsr_valid_q <= 1'b0;
      ret_err_q    <= 1'b0;
    end else begin
      cpsr_q       <= cpsr_d;
      spsr_q       <= spsr_d;
      spsr_valid_q <= spsr_valid_d;
      ret_err_q    <= ret_err_d;
    end
  end

`ifdef FLAG_FORWARD_EN
  // Bypass: the ID-stage checker sees this cycle's flag result immediately
  assign nzcv = cpsr_d;
`else
  assign nzcv = cpsr_q;
`endif

  assign spsr_nzcv  = spsr_q;
  assign spsr_valid = spsr_valid_q;
  assign ret_err    = ret_err_q;

endmodule

// File: tb/tb_status_flag_unit.sv
// tb/tb_status_flag_unit.sv - randomized self-checking bench for status_flag_unit
module tb_status_flag_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] alu_res;
  logic        alu_c, alu_v, sh_c, logic_op, s_bit, ex_valid;
  logic        stall, flush, exc_entry, exc_return;
  logic [3:0]  nzcv, spsr_nzcv;
  logic        spsr_valid, ret_err;

  int checks = 0;
  int errors = 0;

  // reference state
  logic [3:0] m_cpsr, m_spsr;
  logic       m_valid, m_rerr;

  always #5 clk = ~clk;

  status_flag_unit #(.DATA_W(32), .RST_NZCV(4'b0000)) dut (
    .clk(clk), .rst_n(rst_n), .alu_res(alu_res), .alu_c(alu_c), .alu_v(alu_v),
    .sh_c(sh_c), .logic_op(logic_op), .s_bit(s_bit), .ex_valid(ex_valid),
    .stall(stall), .flush(flush), .exc_entry(exc_entry), .exc_return(exc_return),
    .nzcv(nzcv), .spsr_nzcv(spsr_nzcv), .spsr_valid(spsr_valid), .ret_err(ret_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: what the flag registers become after this cycle's inputs
  task automatic model_next(output logic [3:0] nc, output logic [3:0] ns,
                            output logic nv, output logic nr);
    logic [3:0] fl;
    bit n, z, c, v;
    nc = m_cpsr; ns = m_spsr; nv = m_valid; nr = 1'b0;
    if (stall) return;
    if (exc_return) begin
      if (m_valid) begin nc = m_spsr; nv = 1'b0; end
      else nr = 1'b1;
      return;
    end
    n  = (alu_res >= 32'h8000_0000);
    z  = (alu_res == 0);
    c  = logic_op ? sh_c : alu_c;
    v  = logic_op ? (m_cpsr % 2 == 1) : alu_v;
    fl = {n, z, c, v};
    if (ex_valid && s_bit && !flush) nc = fl;
    if (exc_entry) begin ns = nc; nv = 1'b1; end
  endtask

  task automatic set_idle();
    alu_res = 32'h1; alu_c = 0; alu_v = 0; sh_c = 0; logic_op = 0; s_bit = 0;
    ex_valid = 0; stall = 0; flush = 0; exc_entry = 0; exc_return = 0;
  endtask

  // One cycle: inputs already driven; check at negedge, advance model at posedge
  task automatic step();
    logic [3:0] nc, ns;
    logic nv, nr;
    @(negedge clk);
    model_next(nc, ns, nv, nr);
`ifdef FLAG_FORWARD_EN
    check_eq("nzcv_fwd", nzcv, nc);
`else
    check_eq("nzcv", nzcv, m_cpsr);
`endif
    check_eq("spsr_nzcv", spsr_nzcv, m_spsr);
    check_eq("spsr_valid", spsr_valid, m_valid);
    check_eq("ret_err", ret_err, m_rerr);
    @(posedge clk);
    m_cpsr = nc; m_spsr = ns; m_valid = nv; m_rerr = nr;
    #1;
  endtask

  task automatic expect_state(input string tag, input logic [3:0] e_nzcv,
                              input logic [3:0] e_spsr, input logic e_valid);
    set_idle();
    #1;
    check_eq({tag, "_nzcv"}, nzcv, e_nzcv);
    check_eq({tag, "_spsr"}, spsr_nzcv, e_spsr);
    check_eq({tag, "_valid"}, spsr_valid, e_valid);
  endtask

  task automatic arith(input logic [31:0] r, input logic c, input logic v);
    set_idle();
    alu_res = r; alu_c = c; alu_v = v; s_bit = 1; ex_valid = 1;
  endtask

  initial begin
    set_idle();
    rst_n = 0;
    m_cpsr = 0; m_spsr = 0; m_valid = 0; m_rerr = 0;
    #12;
    check_eq("reset_nzcv", nzcv, 4'b0000);
    check_eq("reset_valid", spsr_valid, 1'b0);
    check_eq("reset_ret_err", ret_err, 1'b0);
    @(posedge clk); #1 rst_n = 1;

    // arithmetic update, then s_bit=0 leaves flags alone
    arith(32'h0, 1, 0); step();
    expect_state("arith", 4'b0110, 4'b0000, 0);
    arith(32'h5, 0, 1); s_bit = 0; step();
    expect_state("no_sbit", 4'b0110, 4'b0000, 0);

    // logical update: flush blocks it, otherwise V is held
    arith(32'h1, 0, 1); step();
    expect_state("set0001", 4'b0001, 4'b0000, 0);
    arith(32'h8000_0000, 0, 0); logic_op = 1; sh_c = 1; flush = 1; step();
    expect_state("flushed", 4'b0001, 4'b0000, 0);
    arith(32'h8000_0000, 0, 0); logic_op = 1; sh_c = 1; step();
    expect_state("logical", 4'b1011, 4'b0000, 0);

    // stall holds update + entry until released
    for (int i = 0; i < 3; i++) begin
      arith(32'h0, 0, 0); exc_entry = 1; stall = 1; step();
    end
    expect_state("stalled", 4'b1011, 4'b0000, 0);
    arith(32'h0, 0, 0); exc_entry = 1; step();
    expect_state("unstall", 4'b0100, 4'b0100, 1);

    // exception entry / return / return without saved copy
    set_idle(); exc_return = 1; step();
    arith(32'h8000_0000, 0, 0); step();
    expect_state("set1000", 4'b1000, 4'b0100, 0);
    set_idle(); exc_entry = 1; step();
    expect_state("entry", 4'b1000, 4'b1000, 1);
    arith(32'h0, 0, 0);
    #1;
`ifdef FLAG_FORWARD_EN
    check_eq("fwd_same_cycle", nzcv, 4'b0100);
`else
    check_eq("nofwd_same_cycle", nzcv, 4'b1000);
`endif
    step();
    expect_state("upd0100", 4'b0100, 4'b1000, 1);
    set_idle(); exc_return = 1; step();
    expect_state("return", 4'b1000, 4'b1000, 0);
    set_idle(); exc_return = 1; step();
    set_idle(); #1;
    check_eq("ret_err_pulse", ret_err, 1'b1);
    step();
    check_eq("ret_err_clear", ret_err, 1'b0);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      alu_res    = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      alu_c      = 1'($urandom);
      alu_v      = 1'($urandom);
      sh_c       = 1'($urandom);
      logic_op   = 1'($urandom);
      s_bit      = ($urandom_range(0, 3) != 0);
      ex_valid   = ($urandom_range(0, 3) != 0);
      stall      = ($urandom_range(0, 5) == 0);
      flush      = ($urandom_range(0, 5) == 0);
      exc_entry  = ($urandom_range(0, 7) == 0);
      exc_return = ($urandom_range(0, 7) == 0);
      step();
      if (i == 200) begin
        // asynchronous reset in the middle of a cycle
        @(negedge clk); #2;
        rst_n = 0;
        #1;
        check_eq("async_rst_nzcv", nzcv, 4'b0000);
        check_eq("async_rst_valid", spsr_valid, 1'b0);
        m_cpsr = 0; m_spsr = 0; m_valid = 0; m_rerr = 0;
        @(posedge clk); #1 rst_n = 1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
